// File: rtl/net_pkg.sv
// ---------------------------------------------------------------------------
// net_pkg
// Shared definitions for the receive-side network message path.
//   NETMSG_W        : width of one inbound message word
//   *_LSB           : bit offsets of the message fields inside that word
//   net_msg_t       : packed view of the message word, MSB first
// ---------------------------------------------------------------------------
package net_pkg;

   localparam int NETMSG_W = 122;

   localparam int CPL_LSB  = 120;
   localparam int TPSO_LSB = 96;
   localparam int TASK_LSB = 80;
   localparam int PROC_LSB = 64;
   localparam int PARM_LSB = 32;
   localparam int SPSO_LSB = 0;

   typedef struct packed {
      logic [1:0]  cpl;        // [121:120]
      logic [23:0] tpso;       // [119:96]  target PSO
      logic [15:0] task_id;    // [95:80]
      logic [15:0] proc_indx;  // [79:64]
      logic [31:0] param;      // [63:32]
      logic [31:0] spso;       // [31:0]    source PSO
   } net_msg_t;

endpackage

// File: rtl/net_rx_queue_if.sv
// ---------------------------------------------------------------------------
// net_rx_queue_if
// Bundles the inbound link handshake and the Messenger request side of the
// receive queue.
//   RXVALID/RXFORCE/RXDATA : inbound message from the network controller
//   RXREADY/RXAFULL        : queue back-pressure towards the controller
//   NETREQ/NETPARAM        : head entry presented to the Messenger
//   NETMSGRD               : single-cycle pop confirmation from the Messenger
// Modports: slave = the queue, master = the traffic source/sink around it.
// ---------------------------------------------------------------------------
interface net_rx_queue_if;
   import net_pkg::*;

   logic     RXVALID;
   logic     RXFORCE;
   net_msg_t RXDATA;
   logic     RXREADY;
   logic     RXAFULL;
   logic     NETREQ;
   net_msg_t NETPARAM;
   logic     NETMSGRD;

   modport slave (
      input  RXVALID, RXFORCE, RXDATA, NETMSGRD,
      output RXREADY, RXAFULL, NETREQ, NETPARAM
   );

   modport master (
      output RXVALID, RXFORCE, RXDATA, NETMSGRD,
      input  RXREADY, RXAFULL, NETREQ, NETPARAM
   );

endinterface

// File: rtl/net_fifo_mem.sv
// ---------------------------------------------------------------------------
// net_fifo_mem
// DEPTH x net_msg_t register array with one synchronous write port and one
// asynchronous read port.
//   CLK     : clock
//   we_i    : write enable
//   waddr_i : write index
//   wdata_i : write data
//   raddr_i : read index
//   rdata_o : contents at raddr_i (combinational)
// ---------------------------------------------------------------------------
module net_fifo_mem
   import net_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          CLK,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  net_msg_t      wdata_i,
   input  logic [AW-1:0] raddr_i,
   output net_msg_t      rdata_o
);

   net_msg_t mem_q [DEPTH];

   // NOTE: storage has no reset; empty/full come from the pointers, so stale
   // contents are never observed and the array stays plain flops/RAM.
   always_ff @(posedge CLK) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/net_rx_queue.sv
// ---------------------------------------------------------------------------
// net_rx_queue
// Show-ahead receive FIFO between the network controller inbound link and
// the Messenger network request input.
//   CLK       : clock
//   RESETn    : asynchronous active-low reset
//   bus       : inbound link + Messenger request (net_rx_queue_if.slave)
//   FLUSH     : synchronous clear of queue contents and UNDERFLOW
//   COUNT     : current occupancy, 0..DEPTH
//   DROPCNT   : saturating count of forced messages dropped while full
//   UNDERFLOW : sticky, set by a pop request while empty
// ---------------------------------------------------------------------------
module net_rx_queue
   import net_pkg::*;
#(
   parameter  int DEPTH     = 8,
   localparam int AW        = $clog2(DEPTH),
   parameter  int AFULL_LVL = DEPTH - 2
) (
   input  logic          CLK,
   input  logic          RESETn,
   net_rx_queue_if.slave bus,
   input  logic          FLUSH,
   output logic [AW:0]   COUNT,
   output logic [15:0]   DROPCNT,
   output logic          UNDERFLOW
);

   localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
   localparam logic [AW:0] AFULL_CNT = (AW+1)'(AFULL_LVL);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0] wptr_q, wptr_d;
   logic [AW:0] rptr_q, rptr_d;
   logic [AW:0] count_q, count_d;
   logic        afull_q;
   logic        netreq_q, netreq_d;
   net_msg_t    netparam_q;
   logic [15:0] dropcnt_q, dropcnt_d;
   logic        underflow_q, underflow_d;
   logic        ready_en_q;   // holds RXREADY low until the first edge after reset

   logic        full, empty;
   logic        push, pop, drop;
   net_msg_t    head;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

   assign push = bus.RXVALID & bus.RXREADY;
   assign pop  = bus.NETMSGRD & ~empty;
   // Full is judged on pre-edge state, so a forced message is dropped even
   // when a pop frees a slot on the same edge.
   assign drop = bus.RXVALID & bus.RXFORCE & full;

   net_fifo_mem #(.DEPTH(DEPTH)) u_mem (
      .CLK     (CLK),
      .we_i    (push & ~FLUSH),
      .waddr_i (wptr_q[AW-1:0]),
      .wdata_i (bus.RXDATA),
      .raddr_i (rptr_q[AW-1:0]),
      .rdata_o (head)
   );

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      dropcnt_d   = dropcnt_q;
      underflow_d = underflow_q;

      if (FLUSH) begin
         wptr_d      = '0;
         rptr_d      = '0;
         underflow_d = 1'b0;
      end else begin
         if (push)                    wptr_d      = wptr_q + PTR_ONE;
         if (pop)                     rptr_d      = rptr_q + PTR_ONE;
         if (bus.NETMSGRD && empty)   underflow_d = 1'b1;
      end

      if (drop && (dropcnt_q != 16'hFFFF)) begin
         dropcnt_d = dropcnt_q + 16'd1;
      end

      count_d  = wptr_d - rptr_d;
      // A pop forces a one-cycle gap so the Messenger, which samples NETREQ
      // as a level, cannot dispatch the consumed entry a second time.
      netreq_d = ~empty & ~pop & ~FLUSH;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         afull_q     <= 1'b0;
         netreq_q    <= 1'b0;
         netparam_q  <= '0;
         dropcnt_q   <= '0;
         underflow_q <= 1'b0;
         ready_en_q  <= 1'b0;
      end else begin
         ready_en_q  <= 1'b1;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         afull_q     <= (count_d >= AFULL_CNT);
         netreq_q    <= netreq_d;
         dropcnt_q   <= dropcnt_d;
         underflow_q <= underflow_d;
         // Tracking the head every non-empty cycle covers both a new head
         // after a pop and the empty-to-non-empty transition.
         if (!empty && !FLUSH) begin
            netparam_q <= head;
         end
      end
   end

   assign bus.RXREADY  = ready_en_q & ~full;
   assign bus.RXAFULL  = afull_q;
   assign bus.NETREQ   = netreq_q;
   assign bus.NETPARAM = netparam_q;
   assign COUNT        = count_q;
   assign DROPCNT      = dropcnt_q;
   assign UNDERFLOW    = underflow_q;

endmodule

// File: tb/tb_net_rx_queue.sv
// ---------------------------------------------------------------------------
// tb_net_rx_queue
// Directed bench for net_rx_queue (DEPTH=8, AFULL_LVL=6). Inputs change 1ns
// after each rising edge; outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_net_rx_queue;
   import net_pkg::*;

   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic        CLK    = 1'b0;
   logic        RESETn = 1'b0;
   logic        FLUSH  = 1'b0;
   logic [AW:0] COUNT;
   logic [15:0] DROPCNT;
   logic        UNDERFLOW;

   int errors = 0;
   int checks = 0;

   net_msg_t exp_q [$];
   net_msg_t exp_m;
   net_msg_t d0;

   net_rx_queue_if bus();

   net_rx_queue #(.DEPTH(DEPTH)) dut (
      .CLK       (CLK),
      .RESETn    (RESETn),
      .bus       (bus),
      .FLUSH     (FLUSH),
      .COUNT     (COUNT),
      .DROPCNT   (DROPCNT),
      .UNDERFLOW (UNDERFLOW)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input net_msg_t obs, input net_msg_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chkn(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      chkn({tag, "_rxready"},   int'(bus.RXREADY), 0);
      chkn({tag, "_rxafull"},   int'(bus.RXAFULL), 0);
      chkn({tag, "_netreq"},    int'(bus.NETREQ),  0);
      chk ({tag, "_netparam"},  bus.NETPARAM,      '0);
      chkn({tag, "_count"},     int'(COUNT),       0);
      chkn({tag, "_dropcnt"},   int'(DROPCNT),     0);
      chkn({tag, "_underflow"}, int'(UNDERFLOW),   0);
   endtask

   // Distinct message per index, built from the field offsets.
   function automatic net_msg_t mk(input int i);
      logic [NETMSG_W-1:0] v;
      v = '0;
      v[CPL_LSB  +: 2]  = 2'b10;
      v[TPSO_LSB +: 24] = 24'(i * 3);
      v[TASK_LSB +: 16] = 16'(i);
      v[PROC_LSB +: 16] = 16'(i + 7);
      v[PARM_LSB +: 32] = 32'h5A5A_0000 ^ 32'(i);
      v[SPSO_LSB +: 32] = 32'h0000_1000 + 32'(i);
      return net_msg_t'(v);
   endfunction

   initial begin
      bus.RXVALID  = 1'b0;
      bus.RXFORCE  = 1'b0;
      bus.RXDATA   = '0;
      bus.NETMSGRD = 1'b0;
      d0 = 122'h1_00ABCD_0005_0003_DEADBEEF_00000010;

      // Reset held across an edge
      step();
      check_idle("reset");
      #5;
      RESETn = 1'b1;
      step();
      chkn("ready_after_reset", int'(bus.RXREADY), 1);

      // Single push into empty queue: two-edge latency to NETREQ
      bus.RXVALID = 1'b1;
      bus.RXDATA  = d0;
      step();
      bus.RXVALID = 1'b0;
      chkn("p1_count", int'(COUNT), 1);
      chkn("p1_netreq_early", int'(bus.NETREQ), 0);
      step();
      chkn("p1_netreq", int'(bus.NETREQ), 1);
      chk ("p1_netparam", bus.NETPARAM, d0);
      chkn("p1_count2", int'(COUNT), 1);

      bus.NETMSGRD = 1'b1;
      step();
      bus.NETMSGRD = 1'b0;
      chkn("p1_pop_netreq", int'(bus.NETREQ), 0);
      chkn("p1_pop_count", int'(COUNT), 0);
      step();
      chkn("p1_empty_netreq", int'(bus.NETREQ), 0);

      // Fill to DEPTH
      for (int i = 0; i < DEPTH; i++) begin
         bus.RXVALID = 1'b1;
         bus.RXDATA  = mk(i);
         exp_q.push_back(mk(i));
         step();
         chkn($sformatf("fill_count_%0d", i), int'(COUNT), i + 1);
         chkn($sformatf("fill_afull_%0d", i), int'(bus.RXAFULL), (i + 1 >= 6) ? 1 : 0);
         chkn($sformatf("fill_ready_%0d", i), int'(bus.RXREADY), (i + 1 < 8) ? 1 : 0);
      end
      chkn("full_netreq", int'(bus.NETREQ), 1);
      chk ("full_netparam", bus.NETPARAM, mk(0));

      // Unforced message while full: source holds, nothing changes
      bus.RXDATA  = mk(99);
      bus.RXFORCE = 1'b0;
      step();
      chkn("hold_count", int'(COUNT), 8);
      chkn("hold_dropcnt", int'(DROPCNT), 0);

      // Forced messages while full are dropped
      bus.RXFORCE = 1'b1;
      repeat (3) step();
      bus.RXVALID = 1'b0;
      bus.RXFORCE = 1'b0;
      chkn("drop3_dropcnt", int'(DROPCNT), 3);
      chkn("drop3_count", int'(COUNT), 8);

      // One pop from full: re-arm gap then entry #2
      bus.NETMSGRD = 1'b1;
      exp_m = exp_q.pop_front();
      step();
      bus.NETMSGRD = 1'b0;
      chkn("gap_netreq", int'(bus.NETREQ), 0);
      chkn("gap_count", int'(COUNT), 7);
      chkn("gap_ready", int'(bus.RXREADY), 1);
      chkn("gap_afull", int'(bus.RXAFULL), 1);
      step();
      chkn("rearm_netreq", int'(bus.NETREQ), 1);
      chk ("rearm_netparam", bus.NETPARAM, mk(1));

      // Pop down to four entries
      bus.NETMSGRD = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp_m = exp_q.pop_front();
         step();
         chk($sformatf("drain_a_%0d", i), bus.NETPARAM, exp_m);
      end
      bus.NETMSGRD = 1'b0;
      chkn("four_count", int'(COUNT), 4);
      chkn("four_afull", int'(bus.RXAFULL), 0);

      // Continuous push and pop at COUNT=4, pointers wrap
      for (int i = 0; i < 20; i++) begin
         bus.RXVALID  = 1'b1;
         bus.NETMSGRD = 1'b1;
         bus.RXDATA   = mk(100 + i);
         exp_m = exp_q.pop_front();
         exp_q.push_back(mk(100 + i));
         step();
         chk ($sformatf("stream_data_%0d", i), bus.NETPARAM, exp_m);
         chkn($sformatf("stream_count_%0d", i), int'(COUNT), 4);
      end
      bus.RXVALID  = 1'b0;
      bus.NETMSGRD = 1'b0;
      step();
      chkn("stream_end_netreq", int'(bus.NETREQ), 1);
      chk ("stream_end_head", bus.NETPARAM, mk(116));

      // Drain remaining four
      bus.NETMSGRD = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_m = exp_q.pop_front();
         step();
         chk($sformatf("drain_b_%0d", i), bus.NETPARAM, exp_m);
      end
      bus.NETMSGRD = 1'b0;
      chkn("drained_count", int'(COUNT), 0);
      step();

      // Underflow is sticky until FLUSH
      bus.NETMSGRD = 1'b1;
      step();
      bus.NETMSGRD = 1'b0;
      chkn("uf_set", int'(UNDERFLOW), 1);
      chkn("uf_count", int'(COUNT), 0);
      chkn("uf_netreq", int'(bus.NETREQ), 0);
      step();
      chkn("uf_sticky", int'(UNDERFLOW), 1);
      FLUSH = 1'b1;
      step();
      FLUSH = 1'b0;
      chkn("uf_flushed", int'(UNDERFLOW), 0);

      // Refill, then drive DROPCNT into saturation
      for (int i = 0; i < DEPTH; i++) begin
         bus.RXVALID = 1'b1;
         bus.RXDATA  = mk(200 + i);
         exp_q.push_back(mk(200 + i));
         step();
      end
      chkn("refill_count", int'(COUNT), 8);
      bus.RXFORCE = 1'b1;
      bus.RXDATA  = mk(999);
      for (int i = 0; i < 65531; i++) step();
      chkn("sat_fffe", int'(DROPCNT), 16'hFFFE);
      step();
      chkn("sat_ffff_a", int'(DROPCNT), 16'hFFFF);
      step();
      step();
      chkn("sat_ffff_b", int'(DROPCNT), 16'hFFFF);
      bus.RXVALID = 1'b0;
      bus.RXFORCE = 1'b0;
      chkn("sat_count", int'(COUNT), 8);

      // Pop to COUNT=5; dropped data never entered the queue
      bus.NETMSGRD = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp_m = exp_q.pop_front();
         step();
         chk($sformatf("drain_c_%0d", i), bus.NETPARAM, exp_m);
      end
      bus.NETMSGRD = 1'b0;
      chkn("five_count", int'(COUNT), 5);

      // FLUSH wins over simultaneous push and pop
      FLUSH        = 1'b1;
      bus.RXVALID  = 1'b1;
      bus.RXDATA   = mk(500);
      bus.NETMSGRD = 1'b1;
      step();
      FLUSH        = 1'b0;
      bus.RXVALID  = 1'b0;
      bus.NETMSGRD = 1'b0;
      exp_q.delete();
      chkn("flush_count", int'(COUNT), 0);
      chkn("flush_netreq", int'(bus.NETREQ), 0);
      chkn("flush_dropcnt", int'(DROPCNT), 16'hFFFF);
      chkn("flush_afull", int'(bus.RXAFULL), 0);
      step();
      chkn("flush_netreq2", int'(bus.NETREQ), 0);
      chkn("flush_count2", int'(COUNT), 0);

      // Asynchronous reset in the middle of a burst
      for (int i = 0; i < 7; i++) begin
         bus.RXVALID = 1'b1;
         bus.RXDATA  = mk(300 + i);
         step();
      end
      chkn("burst_count", int'(COUNT), 7);
      chkn("burst_netreq", int'(bus.NETREQ), 1);
      #2;
      RESETn = 1'b0;
      #1;
      check_idle("midreset");
      bus.RXVALID = 1'b0;
      @(negedge CLK);
      RESETn = 1'b1;
      step();
      chkn("post_reset_ready", int'(bus.RXREADY), 1);
      chkn("post_reset_count", int'(COUNT), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/net_rx_queue.md
Name: net_rx_queue

Overview:
- Receive-side message buffer between the network controller's inbound link and the Messenger's network request input (NETREQ/NETPARAM/NETMSGRD).
- Accepts 122-bit inbound message words with a valid/ready handshake and stores them in a show-ahead FIFO.
- Presents the head entry to the Messenger as a level request and pops on the Messenger's single-cycle read confirmation.
- Also handles drop accounting for non-stallable traffic, flush, and underflow reporting.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- AW, $clog2(DEPTH), pointer index width; derived, not overridden.
- AFULL_LVL, DEPTH-2, occupancy at or above which RXAFULL asserts.

Ports:
- CLK  in  1  clock.
- RESETn  in  1  reset; asynchronous, active-low.
- RXVALID  in  1  inbound message valid from network controller.
- RXFORCE  in  1  qualifies RXVALID; message cannot be stalled (drop if full).
- RXDATA  in  122  message: CPL[121:120], TargetPSO[119:96], TaskID[95:80], ProcINDX[79:64], Parameter[63:32], SourcePSO[31:0].
- RXREADY  out  1  queue can accept this cycle (not full).
- RXAFULL  out  1  occupancy >= AFULL_LVL.
- NETREQ  out  1  head entry available to Messenger.
- NETPARAM  out  122  head entry data.
- NETMSGRD  in  1  single-cycle pop pulse from Messenger.
- FLUSH  in  1  synchronous clear of queue contents.
- COUNT  out  AW+1  current occupancy, 0..DEPTH.
- DROPCNT  out  16  dropped-message counter, saturating.
- UNDERFLOW  out  1  sticky: pop seen while empty.

Behaviour:
- Reset (async, RESETn low): pointers 0, COUNT=0, NETREQ=0, RXREADY=0 while RESETn low, then 1 from the first edge after release. RXAFULL=0, DROPCNT=0, UNDERFLOW=0, NETPARAM=0. Storage contents are don't-care.
- Storage: DEPTH x 122 register array. Write/read pointers are AW+1 bits (wrap bit). Full = same index, differing wrap bit. Empty = pointers equal. Pointers wrap naturally modulo 2*DEPTH.
- RXREADY: combinational ~full (and not in reset).
- Push: RXVALID & RXREADY at edge k writes RXDATA at wptr and increments wptr.
- Drop: RXVALID & RXFORCE & full increments DROPCNT, which saturates at 16'hFFFF. The data is discarded and the state is otherwise unchanged.
- RXVALID & ~RXFORCE & full: no action; the source holds.
- NETPARAM: registered copy of the head entry, updated whenever the head changes or the queue transitions from empty to non-empty.
- NETREQ timing:
  - Entry accepted into an empty queue at edge k: NETPARAM valid and NETREQ=1 after edge k+1 (2-cycle latency).
  - NETREQ is a registered level: it is 1 iff the queue is non-empty and no re-arm gap is active.
- Pop: NETMSGRD while non-empty increments rptr at that edge.
  - NETREQ is forced 0 for exactly the cycle after the pop edge (re-arm gap). This prevents the Messenger microcode, which samples the request as a level, from re-dispatching the consumed entry.
  - NETREQ returns to 1 on the following edge if entries remain, with NETPARAM already showing the new head.
- Pop while empty: ignored, pointers unchanged, UNDERFLOW set. UNDERFLOW clears only on reset or FLUSH.
- Simultaneous push and pop:
  - Non-empty: both occur and COUNT is unchanged.
  - Empty: pop is an underflow; push proceeds.
  - Full: RXREADY=0, so only the pop occurs. A forced message in that cycle is dropped, because the full decision uses pre-edge state.
- FLUSH (sync):
  - At the edge, pointers reset, COUNT=0, NETREQ=0 next cycle, UNDERFLOW cleared.
  - DROPCNT is retained.
  - A push or pop in the same cycle is ignored; FLUSH has priority.
- COUNT = wptr - rptr (AW+1 bit subtraction), registered. RXAFULL is registered from the post-update COUNT.
- Reset mid-operation: all state clears immediately; no partial pop or push survives.

Decomposition:
- Shared package (net_pkg): NETMSG_W=122 and field offset constants (CPL_LSB=120, TPSO_LSB=96, TASK_LSB=80, PROC_LSB=64, PARM_LSB=32, SPSO_LSB=0), plus a packed struct type net_msg_t for the 122-bit word.
- One sub-module: net_fifo_mem (register array, write port, async read at index).
- The top handles pointers, flags, re-arm gap, counters and the NETPARAM register.

Test Plan:
- Push RXDATA=122'h1_00ABCD_0005_0003_DEADBEEF_00000010 into empty queue -> NETREQ=1 and NETPARAM equal to it two edges later, COUNT=1.
- Fill DEPTH=8 entries, then pulse NETMSGRD once -> RXREADY=0 at COUNT=8, RXAFULL=1 from COUNT=6. After the pop: NETREQ=0 for one cycle, then 1 with entry #2 on NETPARAM, COUNT=7.
- Full queue with RXVALID=RXFORCE=1 for 3 cycles -> DROPCNT=3, contents unchanged; preload DROPCNT to 16'hFFFE and drop 3 -> saturates at 16'hFFFF.
- Continuous push and pop at COUNT=4 for 20 cycles with incrementing data -> COUNT stays 4, output order matches input order, pointers wrap without loss.
- NETMSGRD pulse on empty queue -> UNDERFLOW=1, COUNT=0; then FLUSH -> UNDERFLOW=0.
- FLUSH asserted together with push and pop at COUNT=5 -> COUNT=0, NETREQ=0 next cycle, DROPCNT unchanged; RESETn low mid-burst -> all outputs return to reset values asynchronously.
